boot_sequencer: RTL and testbench



---
 rtl/boot_seq_pkg.sv | 62 ++++++
 rtl/boot_sequencer_ram_port_mux.sv | 42 ++++
 rtl/boot_sequencer.sv | 154 +++++++++++++++
 tb/tb_boot_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/boot_seq_pkg.sv
// Shared types and helpers for the boot sequencer: state encoding, RAM port
// select codes and the per-state control output decode.
package boot_seq_pkg;

  localparam int CNT_W  = 24;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LDR_RST = 3'd1,
    ST_LOAD    = 3'd2,
    ST_CPU_RST = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_RUN     = 3'd5,
    ST_HALT    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_LDR  = 2'd1;
  localparam logic [1:0] SEL_CPU  = 2'd2;

  typedef struct packed {
    logic cpu_reset;
    logic loader_rst;
    logic load;
    logic rdy;
    logic halted;
    logic error;
  } ctrl_t;

  // Unknown encodings fall back to the IDLE pattern, which keeps the cpu in reset.
  function automatic ctrl_t ctrl_decode(input state_t st);
    ctrl_t c;
    c = '{cpu_reset: 1'b0, loader_rst: 1'b0, load: 1'b0,
          rdy: 1'b0, halted: 1'b0, error: 1'b0};
    case (st)
      ST_IDLE:    begin c.cpu_reset = 1'b1; c.loader_rst = 1'b1; end
      ST_LDR_RST: begin c.cpu_reset = 1'b1; c.loader_rst = 1'b1; end
      ST_LOAD:    begin c.cpu_reset = 1'b1; c.load = 1'b1; end
      ST_CPU_RST: c.cpu_reset = 1'b1;
      ST_SETTLE:  c.cpu_reset = 1'b0;
      ST_RUN:     c.rdy = 1'b1;
      ST_HALT:    c.halted = 1'b1;
      ST_ERROR:   begin c.cpu_reset = 1'b1; c.error = 1'b1; end
      default:    begin c.cpu_reset = 1'b1; c.loader_rst = 1'b1; end
    endcase
    return c;
  endfunction

  function automatic logic [1:0] ram_sel_decode(input state_t st);
    logic [1:0] s;
    case (st)
      ST_LOAD:                     s = SEL_LDR;
      ST_SETTLE, ST_RUN, ST_HALT:  s = SEL_CPU;
      default:                     s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/boot_sequencer_ram_port_mux.sv
// Combinational selection of the RAM_loader port, the cpu bus or an idle
// (all-zero) pattern onto the single RAM port.
module ram_port_mux
  import boot_seq_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic              ldr_we,
  input  logic [DATA_W-1:0] ldr_data,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_do,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din
);

  // Port select; anything but the two owners parks the RAM with writes off.
  always_comb begin
    ram_addr = {ADDR_W{1'b0}};
    ram_we   = 1'b0;
    ram_din  = {DATA_W{1'b0}};
    case (sel)
      SEL_LDR: begin
        ram_addr = ldr_addr;
        ram_we   = ldr_we;
        ram_din  = ldr_data;
      end
      SEL_CPU: begin
        ram_addr = cpu_ab;
        ram_we   = cpu_we;
        ram_din  = cpu_do;
      end
      default: begin
        ram_addr = {ADDR_W{1'b0}};
        ram_we   = 1'b0;
        ram_din  = {DATA_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot controller: sequences RAM_loader reset/load, cpu reset, settle and a
// bounded RUN window, and hands the single RAM port to the current owner.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 10,
  parameter int LOAD_TIMEOUT  = 64,
  parameter int RUN_CYCLES    = 1380
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              loader_done,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic              ldr_we,
  input  logic [DATA_W-1:0] ldr_data,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_do,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  output logic              loader_rst,
  output logic              load,
  output logic              cpu_reset,
  output logic              rdy,
  output logic [2:0]        state,
  output logic              halted,
  output logic              error,
  output logic [CNT_W-1:0]  run_count
);

  // A state with dwell N exits when the counter reaches N-1.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);

  state_t           state_r;
  state_t           state_next_s;
  ctrl_t            ctrl_r;
  ctrl_t            ctrl_next_s;
  logic [CNT_W-1:0] dwell_r;
  logic [CNT_W-1:0] run_count_r;
  logic [1:0]       ram_sel_s;
  logic             cpu_we_gated_s;

  // State and control flops; controls are decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ctrl_r  <= ctrl_decode(ST_IDLE);
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= ctrl_next_s;
    end
  end

  // Next-state logic; dropping start aborts from anywhere and overrides the rest.
  always_comb begin
    state_next_s = state_r;
    if (!start && (state_r != ST_IDLE)) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_next_s = ST_LDR_RST;
          else       state_next_s = ST_IDLE;
        end
        ST_LDR_RST: begin
          if (dwell_r == RST_LAST) state_next_s = ST_LOAD;
          else                     state_next_s = ST_LDR_RST;
        end
        ST_LOAD: begin
          if (loader_done)               state_next_s = ST_CPU_RST;
          else if (dwell_r == LOAD_LAST) state_next_s = ST_ERROR;
          else                           state_next_s = ST_LOAD;
        end
        ST_CPU_RST: begin
          if (dwell_r == RST_LAST) state_next_s = ST_SETTLE;
          else                     state_next_s = ST_CPU_RST;
        end
        ST_SETTLE: begin
          if (dwell_r == SETTLE_LAST) state_next_s = ST_RUN;
          else                        state_next_s = ST_SETTLE;
        end
        ST_RUN: begin
          if (dwell_r == RUN_LAST) state_next_s = ST_HALT;
          else                     state_next_s = ST_RUN;
        end
        ST_HALT:  state_next_s = ST_HALT;
        ST_ERROR: state_next_s = ST_ERROR;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // Control output decode of the upcoming state.
  always_comb begin
    ctrl_next_s = ctrl_decode(state_next_s);
  end

  // Shared dwell counter: restarts at zero on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_r <= {CNT_W{1'b0}};
    end else if (state_next_s != state_r) begin
      dwell_r <= {CNT_W{1'b0}};
    end else begin
      dwell_r <= dwell_r + CNT_W'(1'b1);
    end
  end

  // RDY-high cycle count: cleared when a new boot begins, held outside RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_count_r <= {CNT_W{1'b0}};
    end else if ((state_next_s == ST_LDR_RST) && (state_r != ST_LDR_RST)) begin
      run_count_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      run_count_r <= run_count_r + CNT_W'(1'b1);
    end else begin
      run_count_r <= run_count_r;
    end
  end

  assign ram_sel_s      = ram_sel_decode(state_r);
  assign cpu_we_gated_s = cpu_we & ~ctrl_r.cpu_reset;

  ram_port_mux u_ram_port_mux (
    .sel      (ram_sel_s),
    .ldr_addr (ldr_addr),
    .ldr_we   (ldr_we),
    .ldr_data (ldr_data),
    .cpu_ab   (cpu_ab),
    .cpu_we   (cpu_we_gated_s),
    .cpu_do   (cpu_do),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din)
  );

  assign state      = state_r;
  assign cpu_reset  = ctrl_r.cpu_reset;
  assign loader_rst = ctrl_r.loader_rst;
  assign load       = ctrl_r.load;
  assign rdy        = ctrl_r.rdy;
  assign halted     = ctrl_r.halted;
  assign error      = ctrl_r.error;
  assign run_count  = run_count_r;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: a vector table walks a normal boot and a
// load timeout, then hand sequences cover done-at-timeout, abort and resets.
module tb_boot_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        loader_done;
  logic [15:0] ldr_addr;
  logic        ldr_we;
  logic [7:0]  ldr_data;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic        loader_rst;
  logic        load;
  logic        cpu_reset;
  logic        rdy;
  logic [2:0]  state;
  logic        halted;
  logic        error;
  logic [23:0] run_count;

  boot_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .loader_done(loader_done),
    .ldr_addr(ldr_addr), .ldr_we(ldr_we), .ldr_data(ldr_data),
    .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .loader_rst(loader_rst), .load(load), .cpu_reset(cpu_reset), .rdy(rdy),
    .state(state), .halted(halted), .error(error), .run_count(run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cpu_reset, loader_rst, load, rdy, halted, error}
  localparam logic [5:0] C_IDLE = 6'b110000;
  localparam logic [5:0] C_LOAD = 6'b101000;
  localparam logic [5:0] C_CRST = 6'b100000;
  localparam logic [5:0] C_SET  = 6'b000000;
  localparam logic [5:0] C_RUN  = 6'b000100;
  localparam logic [5:0] C_HALT = 6'b000010;
  localparam logic [5:0] C_ERR  = 6'b100001;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P_LDR  = 2'd1;
  localparam logic [1:0] P_CPU  = 2'd2;

  typedef struct {
    int         n;
    logic       start;
    logic       done;
    logic [2:0] st;
    logic [5:0] ctrl;
    logic [1:0] port;
    int         rc;
  } vec_t;

  vec_t vecs[21];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] ctrl_now();
    return {cpu_reset, loader_rst, load, rdy, halted, error};
  endfunction

  initial begin
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_din;

    reset = 1'b1; start = 1'b0; loader_done = 1'b0;
    ldr_addr = 16'h0200; ldr_we = 1'b1; ldr_data = 8'hA9;
    cpu_ab   = 16'h0300; cpu_we = 1'b1; cpu_do   = 8'h5C;

    // Normal boot with loader_done 40 cycles into LOAD, abort from HALT,
    // then a second boot that times out in LOAD.
    vecs[0]  = '{1,    1'b0, 1'b0, 3'd0, C_IDLE, P_NONE, 0};
    vecs[1]  = '{1,    1'b1, 1'b0, 3'd1, C_IDLE, P_NONE, 0};
    vecs[2]  = '{7,    1'b1, 1'b0, 3'd1, C_IDLE, P_NONE, 0};
    vecs[3]  = '{1,    1'b1, 1'b0, 3'd2, C_LOAD, P_LDR,  0};
    vecs[4]  = '{39,   1'b1, 1'b0, 3'd2, C_LOAD, P_LDR,  0};
    vecs[5]  = '{1,    1'b1, 1'b1, 3'd3, C_CRST, P_NONE, 0};
    vecs[6]  = '{7,    1'b1, 1'b0, 3'd3, C_CRST, P_NONE, 0};
    vecs[7]  = '{1,    1'b1, 1'b0, 3'd4, C_SET,  P_CPU,  0};
    vecs[8]  = '{9,    1'b1, 1'b0, 3'd4, C_SET,  P_CPU,  0};
    vecs[9]  = '{1,    1'b1, 1'b0, 3'd5, C_RUN,  P_CPU,  0};
    vecs[10] = '{1379, 1'b1, 1'b0, 3'd5, C_RUN,  P_CPU,  1379};
    vecs[11] = '{1,    1'b1, 1'b0, 3'd6, C_HALT, P_CPU,  1380};
    vecs[12] = '{5,    1'b1, 1'b0, 3'd6, C_HALT, P_CPU,  1380};
    vecs[13] = '{1,    1'b0, 1'b0, 3'd0, C_IDLE, P_NONE, 1380};
    vecs[14] = '{1,    1'b1, 1'b0, 3'd1, C_IDLE, P_NONE, 0};
    vecs[15] = '{7,    1'b1, 1'b0, 3'd1, C_IDLE, P_NONE, 0};
    vecs[16] = '{1,    1'b1, 1'b0, 3'd2, C_LOAD, P_LDR,  0};
    vecs[17] = '{63,   1'b1, 1'b0, 3'd2, C_LOAD, P_LDR,  0};
    vecs[18] = '{1,    1'b1, 1'b0, 3'd7, C_ERR,  P_NONE, 0};
    vecs[19] = '{3,    1'b1, 1'b0, 3'd7, C_ERR,  P_NONE, 0};
    vecs[20] = '{1,    1'b0, 1'b0, 3'd0, C_IDLE, P_NONE, 0};

    #22;
    check("rst state", 32'(state), 32'd0);
    check("rst ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    check("rst run_count", 32'(run_count), 32'd0);
    check("rst ram_we", 32'(ram_we), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      start       = vecs[i].start;
      loader_done = vecs[i].done;
      tick(vecs[i].n);
      case (vecs[i].port)
        P_LDR:   begin e_addr = 16'h0200; e_we = 1'b1; e_din = 8'hA9; end
        P_CPU:   begin e_addr = 16'h0300; e_we = 1'b1; e_din = 8'h5C; end
        default: begin e_addr = 16'h0000; e_we = 1'b0; e_din = 8'h00; end
      endcase
      check($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("v%0d ctrl", i), 32'(ctrl_now()), 32'(vecs[i].ctrl));
      check($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(e_addr));
      check($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(e_we));
      check($sformatf("v%0d ram_din", i), 32'(ram_din), 32'(e_din));
      check($sformatf("v%0d run_count", i), 32'(run_count), 32'(vecs[i].rc));
    end
    loader_done = 1'b0;

    // loader_done on the timeout cycle wins, then abort at RUN cycle 200.
    start = 1'b1;
    tick(9);
    check("sim in LOAD", 32'(state), 32'd2);
    tick(63);
    check("sim LOAD cycle 64", 32'(state), 32'd2);
    loader_done = 1'b1;
    tick(1);
    loader_done = 1'b0;
    check("sim done wins", 32'(state), 32'd3);
    check("sim load drop", 32'(load), 32'd0);
    tick(17);
    check("rdy not yet", 32'(rdy), 32'd0);
    tick(1);
    check("rdy rise", 32'(rdy), 32'd1);
    tick(199);
    check("abort pre count", 32'(run_count), 32'd199);
    start = 1'b0;
    tick(1);
    check("abort state", 32'(state), 32'd0);
    check("abort rdy", 32'(rdy), 32'd0);
    check("abort cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort run_count", 32'(run_count), 32'd200);

    // Async reset mid-LOAD, then a full re-run with start held high.
    start = 1'b1;
    tick(19);
    check("mid LOAD load", 32'(load), 32'd1);
    reset = 1'b1;
    #2;
    check("async state", 32'(state), 32'd0);
    check("async ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    check("async ram_addr", 32'(ram_addr), 32'd0);
    check("async ram_we", 32'(ram_we), 32'd0);
    #10;
    reset = 1'b0;
    tick(1);
    check("rerun LDR_RST", 32'(state), 32'd1);
    tick(8);
    check("rerun LOAD", 32'(state), 32'd2);
    tick(5);
    loader_done = 1'b1;
    tick(1);
    loader_done = 1'b0;
    tick(18);
    check("rerun rdy", 32'(rdy), 32'd1);
    tick(1380);
    check("rerun halted", 32'(halted), 32'd1);
    check("rerun rdy low", 32'(rdy), 32'd0);
    check("rerun run_count", 32'(run_count), 32'd1380);

    // Async reset while RUN drops rdy without a clock edge.
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(9);
    loader_done = 1'b1;
    tick(1);
    loader_done = 1'b0;
    tick(28);
    check("pre rst rdy", 32'(rdy), 32'd1);
    check("pre rst run_count", 32'(run_count), 32'd10);
    reset = 1'b1;
    #2;
    check("run rst rdy", 32'(rdy), 32'd0);
    check("run rst cpu_reset", 32'(cpu_reset), 32'd1);
    check("run rst run_count", 32'(run_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
